// File: rtl/tx_frame_sequencer_if.sv
// FIFO read port and modulator byte handshake of the TX frame sequencer.
// The master side is the sequencer, the slave side is the FIFO/modulator.
interface tx_frame_sequencer_if;
  logic       fifo_rden;
  logic [7:0] fifo_data;
  logic       mod_valid;
  logic [7:0] mod_data;
  logic       mod_ready;

  modport master (
    output fifo_rden, mod_valid, mod_data,
    input  fifo_data, mod_ready
  );

  modport slave (
    input  fifo_rden, mod_valid, mod_data,
    output fifo_data, mod_ready
  );
endinterface

// File: rtl/tx_frame_sequencer.sv
// Arbitrates HPS data frames and navigation pings onto the shared acoustic TX path,
// streaming frame bytes from the TX FIFO to the modulator with a guard gap after each frame.
module tx_frame_sequencer #(
    parameter int LEN_W   = 8,
    parameter int GUARD_W = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               data_req,
    input  logic [LEN_W-1:0]   data_len,
    input  logic               nav_req,
    input  logic [LEN_W-1:0]   nav_len,
    input  logic [GUARD_W-1:0] guard_interval,
    tx_frame_sequencer_if.master bus,
    output logic               navig_timer_start,
    output logic               busy,
    output logic               active_src,
    output logic               done_irq,
    output logic [LEN_W-1:0]   bytes_left
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        SEND  = 3'd3,
        GUARD = 3'd4
    } state_t;

    state_t             state;
    logic               pend_data;
    logic               pend_nav;
    logic [LEN_W-1:0]   data_len_q;
    logic [LEN_W-1:0]   nav_len_q;
    logic [GUARD_W-1:0] guard_cnt;
    logic               first_byte;

    logic               grant_nav;
    logic               grant_data;
    logic [LEN_W-1:0]   grant_len;
    logic               handshake;

    // Nav has strict priority; data waits in its pending flag.
    always_comb begin
        grant_nav  = (state == IDLE) && pend_nav;
        grant_data = (state == IDLE) && !pend_nav && pend_data;
        grant_len  = pend_nav ? nav_len_q : data_len_q;
        handshake  = (state == SEND) && bus.mod_valid && bus.mod_ready;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            pend_data         <= 1'b0;
            pend_nav          <= 1'b0;
            data_len_q        <= '0;
            nav_len_q         <= '0;
            guard_cnt         <= '0;
            first_byte        <= 1'b0;
            bus.fifo_rden     <= 1'b0;
            bus.mod_valid     <= 1'b0;
            bus.mod_data      <= '0;
            navig_timer_start <= 1'b0;
            busy              <= 1'b0;
            active_src        <= 1'b0;
            done_irq          <= 1'b0;
            bytes_left        <= '0;
        end else begin
            // A request landing on the cycle its flag is consumed re-arms it.
            if (data_req && (!pend_data || grant_data)) begin
                pend_data  <= 1'b1;
                data_len_q <= data_len;
            end else if (grant_data) begin
                pend_data  <= 1'b0;
            end
            if (nav_req && (!pend_nav || grant_nav)) begin
                pend_nav  <= 1'b1;
                nav_len_q <= nav_len;
            end else if (grant_nav) begin
                pend_nav  <= 1'b0;
            end

            bus.fifo_rden     <= 1'b0;
            navig_timer_start <= 1'b0;
            done_irq          <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_nav || grant_data) begin
                        busy       <= 1'b1;
                        active_src <= grant_nav;
                        bytes_left <= grant_len;
                        first_byte <= 1'b1;
                        if (grant_len == '0) begin
                            state     <= GUARD;
                            done_irq  <= 1'b1;
                            guard_cnt <= guard_interval;
                        end else begin
                            state         <= FETCH;
                            bus.fifo_rden <= 1'b1;
                        end
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    bus.mod_data  <= bus.fifo_data;
                    bus.mod_valid <= 1'b1;
                    state         <= SEND;
                end
                SEND: begin
                    if (handshake) begin
                        bus.mod_valid     <= 1'b0;
                        bytes_left        <= bytes_left - LEN_W'(1);
                        first_byte        <= 1'b0;
                        navig_timer_start <= first_byte && active_src;
                        if (bytes_left == LEN_W'(1)) begin
                            state     <= GUARD;
                            done_irq  <= 1'b1;
                            guard_cnt <= guard_interval;
                        end else begin
                            state         <= FETCH;
                            bus.fifo_rden <= 1'b1;
                        end
                    end
                end
                GUARD: begin
                    // A loaded value of 0 or 1 both mean a single GUARD cycle.
                    if (guard_cnt <= GUARD_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        guard_cnt <= guard_cnt - GUARD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Self-checking bench for tx_frame_sequencer: directed frame table, hand-written
// corner sequences and randomized batches against a frame-level byte model.
module tb_tx_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        data_req = 1'b0;
    logic [7:0]  data_len = '0;
    logic        nav_req = 1'b0;
    logic [7:0]  nav_len = '0;
    logic [31:0] guard_interval = '0;
    logic        navig_timer_start;
    logic        busy;
    logic        active_src;
    logic        done_irq;
    logic [7:0]  bytes_left;

    tx_frame_sequencer_if bus();

    tx_frame_sequencer #(.LEN_W(8), .GUARD_W(32)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .data_req          (data_req),
        .data_len          (data_len),
        .nav_req           (nav_req),
        .nav_len           (nav_len),
        .guard_interval    (guard_interval),
        .bus               (bus.master),
        .navig_timer_start (navig_timer_start),
        .busy              (busy),
        .active_src        (active_src),
        .done_irq          (done_irq),
        .bytes_left        (bytes_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       src;
        logic       first;
    } exp_t;

    typedef struct {
        bit nav;
        int len;
        int guard;
        int stall;
        int exp_busy;
        int exp_rden;
        int exp_navig;
    } vec_t;

    logic [7:0] fifo_q[$];
    exp_t       exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int rden_cnt = 0;
    int navig_cnt = 0;
    int busy_cyc = 0;
    int guard_exp = 1;
    int stall_left = 0;
    bit rnd_ready = 1'b0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Registered TX FIFO: data appears the cycle after the read strobe.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.fifo_data <= '0;
        else if (bus.fifo_rden) begin
            if (fifo_q.size() > 0) bus.fifo_data <= fifo_q.pop_front();
            else                   bus.fifo_data <= 8'hEE;
        end
    end

    // Frame-level monitor: byte order/source, nav pulse timing, hold while stalled, guard length.
    logic       exp_navig = 1'b0;
    logic       stall_hold = 1'b0;
    logic [7:0] hold_data;
    logic [7:0] hold_bl;
    logic       in_guard = 1'b0;
    int         gcnt = 0;
    exp_t       e;

    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            check("navig_timer_start", navig_timer_start, exp_navig);
            exp_navig = 1'b0;
            if (stall_hold) begin
                check("hold_valid", bus.mod_valid, 1);
                check("hold_data", bus.mod_data, hold_data);
                check("hold_bytes_left", bytes_left, hold_bl);
            end
            stall_hold = bus.mod_valid && !bus.mod_ready;
            hold_data  = bus.mod_data;
            hold_bl    = bytes_left;
            if (bus.mod_valid && bus.mod_ready) begin
                check("byte_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("mod_data", bus.mod_data, e.data);
                    check("active_src", active_src, e.src);
                    exp_navig = e.src && e.first;
                end
            end
            if (bus.fifo_rden) rden_cnt++;
            if (navig_timer_start) navig_cnt++;
            if (busy) busy_cyc++;
            if (in_guard && !busy) begin
                check("guard_cycles", gcnt, guard_exp);
                in_guard = 1'b0;
            end
            if (done_irq) begin
                done_cnt++;
                in_guard = 1'b1;
                gcnt = 0;
            end
            if (in_guard && busy) gcnt++;
        end else begin
            exp_navig  = 1'b0;
            stall_hold = 1'b0;
            in_guard   = 1'b0;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        if (rnd_ready) bus.mod_ready = ($urandom_range(0, 3) != 0);
        else begin
            bus.mod_ready = (stall_left == 0);
            if (bus.mod_valid && stall_left > 0) stall_left--;
        end
    endtask

    task automatic load_frame(input bit nav, input int len);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            fifo_q.push_back(b);
            exp_q.push_back('{b, nav, i == 0});
        end
    endtask

    task automatic pulse(input bit d, input bit n, input int dl, input int nl);
        data_req = d;
        nav_req  = n;
        data_len = 8'(dl);
        nav_len  = 8'(nl);
        cycle();
        data_req = 1'b0;
        nav_req  = 1'b0;
    endtask

    task automatic set_guard(input int g);
        guard_interval = 32'(g);
        guard_exp      = (g == 0) ? 1 : g;
    endtask

    task automatic wait_idle(input int target, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (done_cnt >= target && !busy) break;
            cycle();
        end
        if (i == budget) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle: timeout after %0d cycles, done %0d of %0d", budget, done_cnt, target);
        end
        cycle();
        cycle();
    endtask

    vec_t vec[6];

    task automatic run_vec(input int k);
        int d0, r0, n0, b0;
        set_guard(vec[k].guard);
        stall_left = vec[k].stall;
        load_frame(vec[k].nav, vec[k].len);
        d0 = done_cnt; r0 = rden_cnt; n0 = navig_cnt; b0 = busy_cyc;
        pulse(!vec[k].nav, vec[k].nav, vec[k].len, vec[k].len);
        wait_idle(d0 + 1, 200);
        check($sformatf("vec%0d_busy_cycles", k), busy_cyc - b0, vec[k].exp_busy);
        check($sformatf("vec%0d_fifo_rden", k), rden_cnt - r0, vec[k].exp_rden);
        check($sformatf("vec%0d_navig", k), navig_cnt - n0, vec[k].exp_navig);
        check($sformatf("vec%0d_done", k), done_cnt - d0, 1);
        check($sformatf("vec%0d_bytes_drained", k), exp_q.size(), 0);
    endtask

    initial begin
        int d0, r0, n0, i;
        //         nav len guard stall busy rden navig
        vec[0] = '{0, 3, 0,  0, 10, 3, 0};
        vec[1] = '{1, 2, 5,  0, 11, 2, 1};
        vec[2] = '{0, 0, 3,  0,  3, 0, 0};
        vec[3] = '{1, 0, 0,  0,  1, 0, 0};
        vec[4] = '{0, 1, 2, 10, 15, 1, 0};
        vec[5] = '{1, 4, 1,  3, 16, 4, 1};

        bus.mod_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_fifo_rden", bus.fifo_rden, 0);
        check("rst_mod_valid", bus.mod_valid, 0);
        check("rst_mod_data", bus.mod_data, 0);
        check("rst_navig", navig_timer_start, 0);
        check("rst_busy", busy, 0);
        check("rst_active_src", active_src, 0);
        check("rst_done_irq", done_irq, 0);
        check("rst_bytes_left", bytes_left, 0);
        reset_n = 1'b1;
        cycle();
        mon_en = 1'b1;

        for (int k = 0; k < 6; k++) run_vec(k);

        // Simultaneous requests: nav first, then data, with a 5-cycle guard between.
        set_guard(5);
        stall_left = 0;
        load_frame(1, 2);
        load_frame(0, 1);
        d0 = done_cnt; r0 = rden_cnt; n0 = navig_cnt;
        pulse(1, 1, 1, 2);
        wait_idle(d0 + 2, 200);
        check("both_done", done_cnt - d0, 2);
        check("both_rden", rden_cnt - r0, 3);
        check("both_navig", navig_cnt - n0, 1);
        check("both_drained", exp_q.size(), 0);

        // Requests during an active frame: repeated data_req ignored, nav served before pending data.
        set_guard(2);
        load_frame(0, 2);
        load_frame(1, 1);
        load_frame(0, 1);
        d0 = done_cnt; r0 = rden_cnt; n0 = navig_cnt;
        pulse(1, 0, 2, 0);
        repeat (3) cycle();
        pulse(1, 0, 1, 0);
        pulse(1, 0, 7, 0);
        pulse(0, 1, 0, 1);
        wait_idle(d0 + 3, 300);
        check("pend_done", done_cnt - d0, 3);
        check("pend_rden", rden_cnt - r0, 4);
        check("pend_navig", navig_cnt - n0, 1);
        check("pend_drained", exp_q.size(), 0);

        // Request arriving on the very cycle its pending flag is granted is kept.
        set_guard(0);
        load_frame(0, 1);
        load_frame(0, 2);
        d0 = done_cnt; r0 = rden_cnt;
        data_req = 1'b1;
        data_len = 8'd1;
        cycle();
        data_len = 8'd2;
        cycle();
        data_req = 1'b0;
        wait_idle(d0 + 2, 200);
        check("recap_done", done_cnt - d0, 2);
        check("recap_rden", rden_cnt - r0, 3);
        check("recap_drained", exp_q.size(), 0);

        // Reset in SEND with two bytes left aborts without a completion pulse.
        stall_left = 1000;
        load_frame(0, 3);
        pulse(1, 0, 3, 0);
        for (i = 0; i < 20 && !bus.mod_valid; i++) cycle();
        check("t6_first_valid", bus.mod_valid, 1);
        bus.mod_ready = 1'b1;
        stall_left = 1000;
        cycle();
        for (i = 0; i < 20 && !bus.mod_valid; i++) cycle();
        check("t6_bytes_left", bytes_left, 2);
        d0 = done_cnt;
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_valid", bus.mod_valid, 0);
        check("t6_async_busy", busy, 0);
        check("t6_async_bytes_left", bytes_left, 0);
        check("t6_async_rden", bus.fifo_rden, 0);
        repeat (2) cycle();
        fifo_q.delete();
        exp_q.delete();
        reset_n = 1'b1;
        repeat (2) cycle();
        check("t6_no_done", done_cnt - d0, 0);
        check("t6_idle", busy, 0);
        run_vec(0);

        // Randomized batches against the frame-level model.
        rnd_ready = 1'b1;
        for (int b = 0; b < 40; b++) begin
            int kind, dl, nl, nf, nn, nb;
            kind = $urandom_range(0, 2);
            dl = $urandom_range(0, 5);
            nl = $urandom_range(0, 5);
            set_guard($urandom_range(0, 3));
            nf = 0; nn = 0; nb = 0;
            if (kind != 0) begin load_frame(1, nl); nf++; nb += nl; if (nl > 0) nn++; end
            if (kind != 1) begin load_frame(0, dl); nf++; nb += dl; end
            d0 = done_cnt; r0 = rden_cnt; n0 = navig_cnt;
            pulse(kind != 1, kind != 0, dl, nl);
            wait_idle(d0 + nf, 400);
            check($sformatf("rnd%0d_done", b), done_cnt - d0, nf);
            check($sformatf("rnd%0d_rden", b), rden_cnt - r0, nb);
            check($sformatf("rnd%0d_navig", b), navig_cnt - n0, nn);
            check($sformatf("rnd%0d_drained", b), exp_q.size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tx_frame_sequencer.md
Name: tx_frame_sequencer

Overview:
- Sequences the shared acoustic TX path. Arbitrates between two frame requesters: HPS data frames and navigation pings.
- Pulls the frame bytes one at a time from the registered TX FIFO and hands them to the modulator over a valid/ready handshake.
- Pulses the navigation timer on the first transmitted byte of a navigation frame, enforces the guard interval between frames, and raises a completion interrupt.
- Sits between the HPS register block/FIFOs and the modulator.

Parameters:
LEN_W, 8, width of frame byte counts
GUARD_W, 32, width of guard interval counter

Ports:
clk  in  1  system clock
reset_n  in  1  reset
data_req  in  1  single-cycle pulse: HPS data frame ready in FIFO
data_len  in  LEN_W  data frame byte count, sampled with data_req
nav_req  in  1  single-cycle pulse: navigation frame requested
nav_len  in  LEN_W  nav frame byte count, sampled with nav_req
guard_interval  in  GUARD_W  idle cycles inserted after each frame, sampled on entry to GUARD
fifo_rden  out  1  TX FIFO read strobe; fifo_data is valid the following cycle
fifo_data  in  8  TX FIFO read data
mod_valid  out  1  byte valid to modulator
mod_data  out  8  byte to modulator
mod_ready  in  1  modulator accepts byte
navig_timer_start  out  1  one-cycle pulse, first byte of nav frame accepted
busy  out  1  high in any state other than IDLE
active_src  out  1  0 = data frame, 1 = nav frame; valid while busy
done_irq  out  1  one-cycle pulse, frame complete
bytes_left  out  LEN_W  bytes remaining in current frame

Behaviour:
- One clock, asynchronous active-low reset (reset_n).
- Reset values: all outputs 0, both pending flags cleared, state IDLE.
- Reset mid-frame aborts immediately. Bytes already read from the FIFO are lost, and no done_irq is issued.
- Request capture (every state):
  - data_req sets pend_data and latches data_len; nav_req sets pend_nav and latches nav_len.
  - A request for a source that is already pending is ignored, including its length.
  - A request arriving in the same cycle its pending flag is consumed is captured as a new pending request.
- Arbitration in IDLE:
  - If pend_nav is set, nav wins; otherwise data.
  - Simultaneous requests: nav is served first and data stays pending.
  - Grant clears the winner's pending flag, loads bytes_left from its latched length, and sets active_src.
  - Grant with length 0: go to GUARD, pulse done_irq, read no bytes.
  - Grant with length > 0: go to FETCH.
- FETCH (1 cycle): fifo_rden=1. Next state LOAD.
- LOAD (1 cycle): mod_data <= fifo_data, mod_valid <= 1. Next state SEND.
- SEND:
  - Hold mod_valid and mod_data until mod_ready is high; a handshake is mod_valid & mod_ready.
  - On handshake: mod_valid <= 0 and bytes_left decrements.
  - If bytes_left was 1: go to GUARD and pulse done_irq on the transition cycle. Otherwise go to FETCH.
  - navig_timer_start pulses in the cycle after the handshake of byte 0 when active_src=1. Never pulses for data frames.
- GUARD:
  - Load counter with guard_interval and count down.
  - Return to IDLE after exactly guard_interval cycles spent in GUARD. guard_interval=0 means one cycle in GUARD.
- Per-byte cost with mod_ready held high: 3 cycles (FETCH, LOAD, SEND).
- mod_ready has no effect outside SEND. fifo_rden is never asserted outside FETCH.
- FIFO underflow is not detected; the requester guarantees that len bytes are present before pulsing its request.

Test Plan:
1. Reset, then data_req with data_len=3, FIFO holding A1,A2,A3, mod_ready=1, guard=0 -> A1,A2,A3 each accepted 3 cycles apart; done_irq 1 pulse; busy returns low; fifo_rden pulsed exactly 3 times.
2. data_req and nav_req in the same cycle (nav_len=2, data_len=1), guard_interval=5 -> nav frame first with active_src=1; navig_timer_start pulse after its first byte; 5 GUARD cycles; then the data frame; 2 done_irq pulses.
3. mod_ready held low for 10 cycles in SEND -> mod_valid and mod_data stable throughout; bytes_left unchanged until the handshake.
4. data_req with data_len=0 -> no fifo_rden; done_irq pulse; GUARD entered.
5. Second data_req during an active data frame, plus nav_req -> the second data_req is captured as pending and served after the guard; nav is arbitrated before it if both are pending.
6. reset_n asserted in SEND with bytes_left=2 -> outputs 0 asynchronously, no done_irq; a subsequent request behaves as in scenario 1.
